// File: rtl/btn_event_arbiter_if.sv
// Event handshake between btn_event_arbiter (master) and its consumer (slave).
interface btn_event_arbiter_if;
    logic       evt_valid;
    logic       evt_ready;
    logic [1:0] evt_id;
    logic       evt_long;

    modport master (output evt_valid, evt_id, evt_long, input evt_ready);
    modport slave  (input evt_valid, evt_id, evt_long, output evt_ready);
endinterface

// File: rtl/btn_event_arbiter.sv
// Four-button press / long-press event generator with round-robin arbitration.
// Define BTN_EVENT_LONG_PRESS_EN to build the hold counters and long-press events.
module btn_event_arbiter #(
    parameter int unsigned LONG_COUNT = 1000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [3:0]                 btn,
    btn_event_arbiter_if.master        evt
);
    localparam int NB = 4;

    typedef enum logic {IDLE, OFFER} state_t;

    state_t     state, state_d;
    logic [3:0] btn_q, pend, long_pend, req, press, pend_clr;
    logic       armed;
    logic [1:0] rr, win_id, cand, id_q;
    logic       win_found, win_long, load;

    // armed masks the first edge so a button held through reset is not a press
    assign press = btn & ~btn_q & {NB{armed}};
    assign req   = pend | long_pend;

    always_comb begin
        win_found = 1'b0;
        win_id    = rr;
        cand      = rr;
        for (int k = 1; k <= NB; k++) begin
            cand = rr + 2'(k);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
    end

    // a pending press on the winning button always goes before its long-press
    assign win_long = ~pend[win_id];

    always_comb begin
        state_d = state;
        load    = 1'b0;
        case (state)
            IDLE: begin
                if (win_found) begin
                    load    = 1'b1;
                    state_d = OFFER;
                end
            end
            OFFER: begin
                if (evt.evt_ready) begin
                    if (win_found) load    = 1'b1;
                    else           state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign pend_clr = (load && !win_long) ? (4'b0001 << win_id) : 4'b0000;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            btn_q <= '0;
            armed <= 1'b0;
            pend  <= '0;
            rr    <= 2'd3;
            id_q  <= '0;
        end else begin
            state <= state_d;
            btn_q <= btn;
            armed <= 1'b1;
            // set wins over a same-cycle grant so a fresh edge is never dropped
            pend  <= (pend & ~pend_clr) | press;
            if (load) begin
                rr   <= win_id;
                id_q <= win_id;
            end
        end
    end

    assign evt.evt_valid = (state == OFFER);
    assign evt.evt_id    = id_q;

`ifdef BTN_EVENT_LONG_PRESS_EN
    localparam logic [15:0] CNT_MAX = 16'(LONG_COUNT);

    logic [NB-1:0][15:0] hold_cnt;
    logic [3:0]          long_set, long_clr;
    logic                long_q;

    assign long_clr = (load && win_long) ? (4'b0001 << win_id) : 4'b0000;

    // fires only on the LONG_COUNT-1 -> LONG_COUNT step, i.e. once per hold
    always_comb begin
        long_set = '0;
        for (int i = 0; i < NB; i++)
            long_set[i] = btn[i] & armed & (hold_cnt[i] == CNT_MAX - 16'd1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt  <= '0;
            long_pend <= '0;
            long_q    <= 1'b0;
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (!btn[i])
                    hold_cnt[i] <= '0;
                else if (armed && hold_cnt[i] != CNT_MAX)
                    hold_cnt[i] <= hold_cnt[i] + 16'd1;
            end
            long_pend <= (long_pend & ~long_clr) | long_set;
            if (load) long_q <= win_long;
        end
    end

    assign evt.evt_long = long_q;
`else
    assign long_pend    = '0;
    assign evt.evt_long = 1'b0;
`endif

endmodule

// File: tb/tb_btn_event_arbiter.sv
// Bench for btn_event_arbiter: directed scenarios plus random stimulus vs. an event-level model.
module tb_btn_event_arbiter;
    localparam int LC = 8;
`ifdef BTN_EVENT_LONG_PRESS_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] btn = 4'b0;

    btn_event_arbiter_if bus();

    btn_event_arbiter #(.LONG_COUNT(LC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn),
        .evt   (bus.master)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model: pending press / long flags per button, the offered event, last winner.
    bit         m_valid;
    logic [1:0] m_id;
    bit         m_long;
    bit         m_pend  [4];
    bit         m_lpend [4];
    int         m_rr;
    logic [3:0] m_prev;
    bit         m_armed;
    int         m_cnt   [4];

    function automatic void model_reset();
        m_valid = 0; m_id = 2'd0; m_long = 0; m_rr = 3; m_prev = 4'b0; m_armed = 0;
        for (int i = 0; i < 4; i++) begin
            m_pend[i] = 0; m_lpend[i] = 0; m_cnt[i] = 0;
        end
    endfunction

    // One clock edge with inputs b/r presented before it.
    function automatic void model_step(input logic [3:0] b, input logic r);
        int w;
        w = -1;
        if (!m_valid || r) begin
            for (int k = 1; k <= 4; k++) begin
                int i;
                i = (m_rr + k) % 4;
                if (w < 0 && (m_pend[i] || m_lpend[i])) w = i;
            end
            if (w >= 0) begin
                m_valid = 1;
                m_id    = 2'(w);
                m_long  = !m_pend[w];
                if (m_pend[w]) m_pend[w] = 0;
                else           m_lpend[w] = 0;
                m_rr    = w;
            end else begin
                m_valid = 0;
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (m_armed && b[i] && !m_prev[i]) m_pend[i] = 1;
            if (LONG_EN) begin
                if (!b[i]) m_cnt[i] = 0;
                else if (m_armed && m_cnt[i] < LC) begin
                    m_cnt[i]++;
                    if (m_cnt[i] == LC) m_lpend[i] = 1;
                end
            end
        end
        m_prev  = b;
        m_armed = 1;
    endfunction

    // id/long only carry meaning while valid
    function automatic logic [3:0] dut_evt();
        return {bus.evt_valid, bus.evt_valid ? {bus.evt_id, bus.evt_long} : 3'b000};
    endfunction

    function automatic logic [3:0] mdl_evt();
        return {m_valid, m_valid ? {m_id, m_long} : 3'b000};
    endfunction

    task automatic step(input logic [3:0] b, input logic r);
        btn = b;
        bus.evt_ready = r;
        @(posedge clk);
        model_step(b, r);
        #1;
    endtask

    task automatic do_reset(input logic [3:0] b);
        btn = b;
        bus.evt_ready = 1'b0;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        bus.evt_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if (bus.evt_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", bus.evt_valid);
        else n_pass++;
        n_total++;
        if (bus.evt_id !== 2'd0) $display("FAIL reset_id got %0d exp 0", bus.evt_id);
        else n_pass++;
        n_total++;
        if (bus.evt_long !== 1'b0) $display("FAIL reset_long got %b exp 0", bus.evt_long);
        else n_pass++;
        do_reset(4'b0000);
    endtask

    task automatic test_held_at_reset();
        do_reset(4'b0010);
        for (int c = 0; c < 20; c++) begin
            step(4'b0010, 1'b1);
            if (!LONG_EN || c < LC) begin
                n_total++;
                if (bus.evt_valid !== 1'b0) $display("FAIL held_at_reset c=%0d got valid %b exp 0", c, bus.evt_valid);
                else n_pass++;
            end
            n_total++;
            if (dut_evt() !== mdl_evt()) $display("FAIL held_model c=%0d got %h exp %h", c, dut_evt(), mdl_evt());
            else n_pass++;
        end
        repeat (4) step(4'b0000, 1'b1);
    endtask

    task automatic test_single_press();
        do_reset(4'b0000);
        step(4'b0000, 1'b1);
        step(4'b0100, 1'b1);
        n_total++;
        if (bus.evt_valid !== 1'b0) $display("FAIL press_k got valid %b exp 0", bus.evt_valid);
        else n_pass++;
        step(4'b0100, 1'b1);
        n_total++;
        if (dut_evt() !== 4'b1100) $display("FAIL press_k1 got %h exp c", dut_evt());
        else n_pass++;
        step(4'b0100, 1'b1);
        n_total++;
        if (bus.evt_valid !== 1'b0) $display("FAIL press_k2 got valid %b exp 0", bus.evt_valid);
        else n_pass++;
        step(4'b0000, 1'b1);
    endtask

    task automatic test_all_four();
        logic [3:0] exp;
        do_reset(4'b0000);
        step(4'b0000, 1'b1);
        step(4'b1111, 1'b1);
        for (int j = 0; j < 4; j++) begin
            step(4'b1111, 1'b1);
            exp = {1'b1, 2'(j), 1'b0};
            n_total++;
            if (dut_evt() !== exp) $display("FAIL all_four j=%0d got %h exp %h", j, dut_evt(), exp);
            else n_pass++;
        end
        step(4'b1111, 1'b1);
        n_total++;
        if (bus.evt_valid !== 1'b0) $display("FAIL all_four_idle got valid %b exp 0", bus.evt_valid);
        else n_pass++;
        step(4'b0000, 1'b1);
        step(4'b0010, 1'b1);
        step(4'b0010, 1'b1);
        n_total++;
        if (dut_evt() !== 4'b1010) $display("FAIL all_four_again got %h exp a", dut_evt());
        else n_pass++;
        step(4'b0000, 1'b1);
    endtask

    task automatic test_backpressure();
        logic [3:0] pat [10];
        int         seen [$];
        pat = '{4'b1000, 4'b0000, 4'b0000, 4'b1000, 4'b0000,
                4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        do_reset(4'b0000);
        step(4'b0000, 1'b0);
        for (int c = 0; c < 10; c++) begin
            step(pat[c], 1'b0);
            if (c >= 1) begin
                n_total++;
                if (dut_evt() !== 4'b1110) $display("FAIL stall_hold c=%0d got %h exp e", c, dut_evt());
                else n_pass++;
            end
        end
        for (int c = 0; c < 6; c++) begin
            if (bus.evt_valid) seen.push_back(int'(bus.evt_id));
            step(4'b0000, 1'b1);
            n_total++;
            if (dut_evt() !== mdl_evt()) $display("FAIL stall_model c=%0d got %h exp %h", c, dut_evt(), mdl_evt());
            else n_pass++;
        end
        n_total++;
        if (seen.size() != 3) $display("FAIL stall_count got %0d exp 3", seen.size());
        else begin
            n_pass++;
            n_total++;
            if (seen[0] != 3 || seen[1] != 0 || seen[2] != 3)
                $display("FAIL stall_order got %0d,%0d,%0d exp 3,0,3", seen[0], seen[1], seen[2]);
            else n_pass++;
        end
    endtask

    task automatic test_long_press();
        int n_press, n_long, long_edge;
        n_press = 0; n_long = 0; long_edge = -1;
        do_reset(4'b0000);
        step(4'b0000, 1'b1);
        for (int e = 1; e <= 33; e++) begin
            if (bus.evt_valid) begin
                if (bus.evt_long) n_long++;
                else n_press++;
            end
            step((e <= 30) ? 4'b0010 : 4'b0000, 1'b1);
            if (bus.evt_valid && bus.evt_long && long_edge < 0) long_edge = e;
            n_total++;
            if (dut_evt() !== mdl_evt()) $display("FAIL long_model e=%0d got %h exp %h", e, dut_evt(), mdl_evt());
            else n_pass++;
        end
        n_total++;
        if (n_press != 1) $display("FAIL long_press_count got %0d exp 1", n_press);
        else n_pass++;
        n_total++;
        if (n_long != int'(LONG_EN)) $display("FAIL long_count got %0d exp %0d", n_long, int'(LONG_EN));
        else n_pass++;
        n_total++;
        if (long_edge != (LONG_EN ? LC + 1 : -1)) $display("FAIL long_edge got %0d exp %0d", long_edge, LONG_EN ? LC + 1 : -1);
        else n_pass++;
    endtask

    task automatic test_reset_in_offer();
        do_reset(4'b0000);
        step(4'b0000, 1'b0);
        step(4'b0111, 1'b0);
        step(4'b0111, 1'b0);
        n_total++;
        if (dut_evt() !== 4'b1000) $display("FAIL offer_before_rst got %h exp 8", dut_evt());
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if (bus.evt_valid !== 1'b0) $display("FAIL rst_in_offer got valid %b exp 0", bus.evt_valid);
        else n_pass++;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            step((c < 5) ? 4'b0111 : 4'b0000, 1'b1);
            n_total++;
            if (bus.evt_valid !== 1'b0) $display("FAIL post_rst_quiet c=%0d got valid %b exp 0", c, bus.evt_valid);
            else n_pass++;
        end
        step(4'b0100, 1'b1);
        step(4'b0100, 1'b1);
        n_total++;
        if (dut_evt() !== 4'b1100) $display("FAIL post_rst_press got %h exp c", dut_evt());
        else n_pass++;
        step(4'b0000, 1'b1);
    endtask

    task automatic test_random();
        logic [3:0] b;
        logic       r;
        b = 4'b0;
        do_reset(4'b0000);
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < 4; i++)
                if ($urandom_range(0, 9) == 0) b[i] = ~b[i];
            r = ($urandom_range(0, 3) != 0);
            step(b, r);
            n_total++;
            if (dut_evt() !== mdl_evt()) $display("FAIL random c=%0d got %h exp %h", c, dut_evt(), mdl_evt());
            else n_pass++;
        end
    endtask

    initial begin
        bus.evt_ready = 1'b0;
        test_reset();
        test_held_at_reset();
        test_single_press();
        test_all_four();
        test_backpressure();
        test_long_press();
        test_reset_in_offer();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/btn_event_arbiter.md
BTN_EVENT_ARBITER -- requirements
Module: btn_event_arbiter

Interface
REQ-001 Parameter LONG_COUNT, default 1000: clock cycles a button must be held to raise a long-press event (range 2..65535).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 btn  input  4  debounced button levels, one per button, active-high, synchronous to clk.
REQ-005 evt_valid  output  1  event offered on evt_id/evt_long.
REQ-006 evt_ready  input  1  consumer accepts the event; transfer occurs on any cycle with evt_valid=1 and evt_ready=1.
REQ-007 evt_id  output  2  index of the button that produced the offered event.
REQ-008 evt_long  output  1  1 = long-press event, 0 = press event.

Function
REQ-009 btn_q (4 bits) shall register btn every cycle; press edge[i] = btn[i] & ~btn_q[i] & armed.
REQ-010 armed shall be 0 after reset and become 1 at the first clock edge, so a button already held at reset release produces no press event.
REQ-011 A press edge shall set pend[i]; further edges while pend[i]=1 shall coalesce into one event.
REQ-012 Setting and clearing pend[i] in the same cycle shall leave pend[i]=1.
REQ-013 FSM states IDLE and OFFER; IDLE: evt_valid=0; OFFER: evt_valid=1.
REQ-014 IDLE -> OFFER when any request is pending: winner loaded into evt_id/evt_long, winner's pending bit cleared, same edge.
REQ-015 Latency: btn high at edge k (btn_q=0) sets pend at edge k; evt_valid=1 after edge k+1.
REQ-016 OFFER: evt_id and evt_long shall hold stable until transfer.
REQ-017 On transfer: if any request pending, load next winner on the same edge and stay in OFFER (one event per cycle); else go to IDLE.
REQ-018 Arbitration is round-robin: search order rr+1, rr+2, rr+3, rr (mod 4); rr updates to the winner index on load.
REQ-019 Within one button, a pending press shall be granted before a pending long-press; each grant clears only the granted bit.
REQ-020 Events occurring while in OFFER shall be retained in pending bits; no event shall be lost or duplicated.

Reset
REQ-021 rst_n low shall immediately force evt_valid=0, evt_id=0, evt_long=0, FSM=IDLE, pend=0, long_pend=0, btn_q=0, armed=0, rr=3, hold counters=0.
REQ-022 Reset asserted in OFFER shall discard the offered and all pending events.
REQ-023 The first arbitration after reset shall grant button 0 if it requests.

Configuration
REQ-024 Macro BTN_EVENT_LONG_PRESS_EN compiles in long-press detection.
REQ-025 With the macro: per-button 16-bit hold counter increments each cycle while btn[i]=1 and armed, saturates at LONG_COUNT, clears when btn[i]=0.
REQ-026 With the macro: the counter reaching LONG_COUNT (transition LONG_COUNT-1 -> LONG_COUNT) shall set long_pend[i] once per hold.
REQ-027 Without the macro: no counters or long_pend logic are present, evt_long is constant 0, and all other behaviour is identical.

Verification
REQ-028 Reset release with btn=4'b0010 held, hold 20 cycles -> evt_valid stays 0.
REQ-029 btn=4'b0000 -> 4'b0100 at edge k, evt_ready=1 -> evt_valid=1 after edge k+1, evt_id=2, evt_long=0; evt_valid=0 after edge k+2.
REQ-030 All 4 buttons rise at the same edge, evt_ready=1 -> ids 0,1,2,3 on consecutive cycles; then button 1 rises again -> id 1.
REQ-031 evt_ready=0 for 10 cycles while button 3 pulses twice and button 0 once -> evt_id stable at first winner; after ready: exactly one event each for 0 and 3, in round-robin order.
REQ-032 With BTN_EVENT_LONG_PRESS_EN, LONG_COUNT=8, btn[1] held 30 cycles, evt_ready=1 -> one press event (id 1, long 0), then exactly one long event (id 1, long 1) after edge 9 of the hold; without the macro only the press event.
REQ-033 rst_n pulsed low while evt_valid=1 and two requests pending -> evt_valid=0 immediately; no events after reset until a new press edge.
